// File: rtl/bitscan_pkg.sv
// Shared types and helpers for the bit-scan sequencer: FSM state enum and the
// all-ones not-found sentinel.
package bitscan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // All-ones value of the requested width (capped at 32 bits).
    function automatic logic [31:0] not_found(input int unsigned width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

endpackage

// File: rtl/bit_pick.sv
// Combinational priority picker: index of the first set bit in priority order,
// or the not-found sentinel with o_found=0 when the vector is zero.
module bit_pick
    import bitscan_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = 8,
    parameter bit          HIGH_FIRST = 1'b1,
    localparam int unsigned IDX_WIDTH = $clog2(IN_WIDTH) + 1
) (
    input  logic [IN_WIDTH-1:0]  i_vec,
    output logic [IDX_WIDTH-1:0] o_idx,
    output logic                 o_found
);

    // Later loop iterations override earlier ones, so the scan direction sets priority.
    always_comb begin
        o_idx   = IDX_WIDTH'(not_found(IDX_WIDTH));
        o_found = 1'b0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < int'(IN_WIDTH); i++) begin
                if (i_vec[i]) begin
                    o_idx   = IDX_WIDTH'(i);
                    o_found = 1'b1;
                end
            end
        end else begin
            for (int i = int'(IN_WIDTH) - 1; i >= 0; i--) begin
                if (i_vec[i]) begin
                    o_idx   = IDX_WIDTH'(i);
                    o_found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bit_scan_sequencer.sv
// Walks every set bit of an accepted request vector, emitting one index per
// output beat with a last-beat marker; a zero vector yields one not-found beat.
module bit_scan_sequencer
    import bitscan_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = 8,
    parameter bit          HIGH_FIRST = 1'b1,
    localparam int unsigned IDX_WIDTH = $clog2(IN_WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDX_WIDTH-1:0] out_idx,
    output logic                 out_none,
    output logic                 out_last,
    output logic                 busy
);

    localparam logic [IDX_WIDTH-1:0] NOT_FOUND = IDX_WIDTH'(not_found(IDX_WIDTH));
    localparam int unsigned          SEL_WIDTH = IDX_WIDTH - 1;

    state_t                r_state;
    logic [IN_WIDTH-1:0]   r_pending;
    logic                  r_out_valid;
    logic [IDX_WIDTH-1:0]  r_out_idx;
    logic                  r_out_none;
    logic                  r_out_last;

    logic [IDX_WIDTH-1:0]  w_in_idx;
    logic                  w_in_found;
    logic [IDX_WIDTH-1:0]  w_pend_idx;
    logic                  w_pend_found;
    logic [IN_WIDTH-1:0]   w_in_next;
    logic [IN_WIDTH-1:0]   w_pend_next;
    logic                  w_accept;
    logic                  w_handshake;

    bit_pick #(.IN_WIDTH(IN_WIDTH), .HIGH_FIRST(HIGH_FIRST)) u_pick_in (
        .i_vec   (in_vec),
        .o_idx   (w_in_idx),
        .o_found (w_in_found)
    );

    bit_pick #(.IN_WIDTH(IN_WIDTH), .HIGH_FIRST(HIGH_FIRST)) u_pick_pend (
        .i_vec   (r_pending),
        .o_idx   (w_pend_idx),
        .o_found (w_pend_found)
    );

    // Clearing with a sentinel index is harmless: the source vector is zero then.
    assign w_in_next   = in_vec    & ~(IN_WIDTH'(1) << w_in_idx[SEL_WIDTH-1:0]);
    assign w_pend_next = r_pending & ~(IN_WIDTH'(1) << w_pend_idx[SEL_WIDTH-1:0]);

    assign w_handshake = r_out_valid && out_ready;
    assign in_ready    = !flush && ((r_state == IDLE) || (w_handshake && r_out_last));
    assign w_accept    = in_valid && in_ready;

    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_none  = r_out_none;
    assign out_last  = r_out_last;
    assign busy      = (r_state != IDLE);

    // FSM, pending mask and output registers; rst over flush over accept over advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= NOT_FOUND;
            r_out_none  <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= NOT_FOUND;
            r_out_none  <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_state     <= SCAN;
            r_pending   <= w_in_next;
            r_out_valid <= 1'b1;
            r_out_idx   <= w_in_idx;
            r_out_none  <= !w_in_found;
            r_out_last  <= (w_in_next == '0);
        end else if (w_handshake) begin
            if (!r_out_last && w_pend_found) begin
                r_pending  <= w_pend_next;
                r_out_idx  <= w_pend_idx;
                r_out_last <= (w_pend_next == '0);
            end else begin
                r_state     <= IDLE;
                r_pending   <= '0;
                r_out_valid <= 1'b0;
                r_out_none  <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

endmodule
